// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide, one shared 32-step shift engine.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [2:0] op_q;
  logic [5:0] cnt;
  logic [63:0] acc, acc_n, prod;
  logic [31:0] den, ma, mb, spec_res, quo, rmd, res_n;
  logic [32:0] sum, sh, diff;
  logic neg, sa, sb, special;
  always_comb begin
    sa = a[31] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    sb = b[31] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    special = op[2] && (b == '0 || (!op[0] && a == 32'h8000_0000 && b == '1));
    spec_res = b == '0 ? (op[1] ? a : '1) : (op[1] ? '0 : 32'h8000_0000);
    // acc holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
    sum = {1'b0, acc[63:32]} + {1'b0, den};
    sh = acc[63:31];
    diff = sh - {1'b0, den};
    acc_n = op_q[2] ? (sh >= {1'b0, den} ? {diff[31:0], acc[30:0], 1'b1} : {sh[31:0], acc[30:0], 1'b0})
                    : (acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]});
    prod = neg ? -acc_n : acc_n;
    quo = neg ? -acc_n[31:0] : acc_n[31:0];
    rmd = neg ? -acc_n[63:32] : acc_n[63:32];
    res_n = op_q[2] ? (op_q[1] ? rmd : quo) : (op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
    state_n = state == IDLE ? (start ? (special ? FIN : RUN) : IDLE)
            : state == RUN ? (cnt == 6'd31 ? FIN : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= '0;
      cnt <= '0;
      acc <= '0;
      den <= '0;
      neg <= 1'b0;
      result <= '0;
    end else if (state == IDLE && start) begin
      op_q <= op;
      cnt <= '0;
      neg <= (op[2] && op[1]) ? sa : sa ^ sb;
      den <= op[2] ? mb : ma;
      acc <= {32'b0, op[2] ? ma : mb};
      if (special) result <= spec_res;
    end else if (state == RUN) begin
      acc <= acc_n;
      cnt <= cnt + 6'd1;
      if (cnt == 6'd31) result <= res_n;
    end
  assign busy = state == RUN;
  assign done = state == FIN;
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: scoreboard bench for muldiv_iter against an arithmetic reference model.
module tb_muldiv_iter;
  logic clk = 0, rst = 1, start = 0;
  logic [2:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, done;
  logic [31:0] result;
  int vectors = 0, miscompares = 0, cyc = 0;
  typedef struct {logic [31:0] res; int cyc; logic [2:0] op;} exp_t;
  exp_t sbq[$];

  muldiv_iter #(.XLEN(32)) dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    sx = $signed(x); sy = $signed(y);
    ux = {32'b0, x}; uy = {32'b0, y};
    case (o)
      3'd0: p = sx * sy;
      3'd1: p = (sx * sy) >>> 32;
      3'd2: p = (sx * uy) >>> 32;
      3'd3: p = (ux * uy) >> 32;
      3'd4: p = y == 0 ? -1 : sx / sy;
      3'd5: p = y == 0 ? -1 : ux / uy;
      3'd6: p = y == 0 ? ux : sx % sy;
      default: p = y == 0 ? ux : ux % uy;
    endcase
    return p[31:0];
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) ? 0 : 32;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy && done) begin
        miscompares++;
        $display("FAIL busy_done_overlap busy=%b done=%b want not both", busy, done);
      end
      if (done) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done got result=%h cycle=%0d want no done", result, cyc);
        end else begin
          e = sbq.pop_front();
          if (result !== e.res || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL op%0d got result=%h cycle=%0d want result=%h cycle=%0d", e.op, result, cyc, e.res, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout got busy=%b done=%b want idle", busy, done);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    wait_idle();
    start = 1; op = o; a = x; b = y;
    sbq.push_back('{ref_model(o, x, y), cyc + 1 + latency(o, x, y), o});
    @(negedge clk);
    start = 0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_result", result, 0);
    rst = 0;
    @(negedge clk);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_idle();
    repeat (5) @(negedge clk);
    check("mul_hold", result, 32'hFFFF_FFEB);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd7, 32'd100, 32'd7);
    issue(3'd4, 32'd5, 32'd0);
    issue(3'd6, 32'd5, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd5, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    start = 1; op = 3'd0; a = 3; b = 3;
    @(negedge clk);
    start = 0;
    wait_idle();
    start = 1; op = 3'd0; a = 3; b = 3;
    sbq.push_back('{32'd9, cyc + 33, 3'd0});
    sbq.push_back('{32'd9, cyc + 67, 3'd0});
    repeat (41) @(negedge clk);
    start = 0;
    wait_idle();
    issue(3'd0, 32'd1234, 32'd5678);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_result", result, 0);
    sbq.delete();
    @(negedge clk);
    rst = 0;
    issue(3'd3, 32'd2, 32'h8000_0000);
    for (int i = 0; i < 250; i++) issue(3'($urandom_range(0, 7)), pick(), pick());
    wait_idle();
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
